// File: rtl/axil_wr_arbiter.sv
// Two-requester AXI4-Lite write arbiter in front of one shared slave.
// One write is outstanding at a time; simultaneous requests alternate round-robin.
// Optional B-channel timeout with drain of a late slave response: define AXIL_ARB_TIMEOUT_EN.
module axil_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 40,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic [ADDR_WIDTH-1:0] s0_axil_awaddr,
    input  logic                  s0_axil_awvalid,
    output logic                  s0_axil_awready,
    input  logic [DATA_WIDTH-1:0] s0_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s0_axil_wstrb,
    input  logic                  s0_axil_wvalid,
    output logic                  s0_axil_wready,
    output logic [1:0]            s0_axil_bresp,
    output logic                  s0_axil_bvalid,
    input  logic                  s0_axil_bready,

    input  logic [ADDR_WIDTH-1:0] s1_axil_awaddr,
    input  logic                  s1_axil_awvalid,
    output logic                  s1_axil_awready,
    input  logic [DATA_WIDTH-1:0] s1_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s1_axil_wstrb,
    input  logic                  s1_axil_wvalid,
    output logic                  s1_axil_wready,
    output logic [1:0]            s1_axil_bresp,
    output logic                  s1_axil_bvalid,
    input  logic                  s1_axil_bready,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready
);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t state;
    logic   g;           // granted port
    logic   last_grant;  // port that completed the previous write
    logic   aw_done;
    logic   w_done;

    logic req0, req1;
    logic g_awvalid, g_wvalid, g_bready;
    logic aw_hs, w_hs;
    logic grant_ok;

    // Response fields for the granted port before steering to s0/s1.
    logic       g_awready, g_wready, g_bvalid;
    logic [1:0] g_bresp;

    if (TIMEOUT < 2) begin : g_timeout_check
        $error("TIMEOUT must be at least 2");
    end

`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt;
    logic          drain;  // a timed-out slave response is still to be absorbed
    logic          tmo;
    assign tmo      = (state == RESP) && (cnt == '0);
    assign grant_ok = !drain;
`else
    assign grant_ok = 1'b1;
`endif

    assign req0      = s0_axil_awvalid && s0_axil_wvalid;
    assign req1      = s1_axil_awvalid && s1_axil_wvalid;
    assign g_awvalid = g ? s1_axil_awvalid : s0_axil_awvalid;
    assign g_wvalid  = g ? s1_axil_wvalid  : s0_axil_wvalid;
    assign g_bready  = g ? s1_axil_bready  : s0_axil_bready;
    assign aw_hs     = m_axil_awvalid && m_axil_awready;
    assign w_hs      = m_axil_wvalid && m_axil_wready;

    // Channel muxing and handshake gating; everything idles low outside XFER/RESP.
    always_comb begin
        m_axil_awaddr  = g ? s1_axil_awaddr : s0_axil_awaddr;
        m_axil_wdata   = g ? s1_axil_wdata  : s0_axil_wdata;
        m_axil_wstrb   = g ? s1_axil_wstrb  : s0_axil_wstrb;
        m_axil_awvalid = 1'b0;
        m_axil_wvalid  = 1'b0;
        m_axil_bready  = 1'b0;
        g_awready      = 1'b0;
        g_wready       = 1'b0;
        g_bvalid       = 1'b0;
        g_bresp        = 2'b00;
        case (state)
            XFER: begin
                m_axil_awvalid = g_awvalid && !aw_done;
                m_axil_wvalid  = g_wvalid && !w_done;
                g_awready      = m_axil_awready && !aw_done;
                g_wready       = m_axil_wready && !w_done;
            end
            RESP: begin
                g_bvalid      = m_axil_bvalid;
                g_bresp       = m_axil_bresp;
                m_axil_bready = g_bready;
`ifdef AXIL_ARB_TIMEOUT_EN
                // Slave gave up on: answer SLVERR locally, leave its response for the drain.
                if (tmo) begin
                    g_bvalid      = 1'b1;
                    g_bresp       = 2'b10;
                    m_axil_bready = 1'b0;
                end
`endif
            end
            default: ;
        endcase
`ifdef AXIL_ARB_TIMEOUT_EN
        if (drain) m_axil_bready = 1'b1;
`endif
        s0_axil_awready = !g && g_awready;
        s0_axil_wready  = !g && g_wready;
        s0_axil_bvalid  = !g && g_bvalid;
        s0_axil_bresp   = g ? 2'b00 : g_bresp;
        s1_axil_awready = g && g_awready;
        s1_axil_wready  = g && g_wready;
        s1_axil_bvalid  = g && g_bvalid;
        s1_axil_bresp   = g ? g_bresp : 2'b00;
    end

    // Arbitration / transfer / response FSM.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            g          <= 1'b0;
            last_grant <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
`ifdef AXIL_ARB_TIMEOUT_EN
            cnt        <= '0;
            drain      <= 1'b0;
`endif
        end else begin
`ifdef AXIL_ARB_TIMEOUT_EN
            if (drain && m_axil_bvalid) drain <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (grant_ok && (req0 || req1)) begin
                        g     <= (req0 && req1) ? ~last_grant : req1;
                        state <= XFER;
                    end
                end
                XFER: begin
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= RESP;
`ifdef AXIL_ARB_TIMEOUT_EN
                        cnt     <= CW'(TIMEOUT - 1);
`endif
                    end else begin
                        if (aw_hs) aw_done <= 1'b1;
                        if (w_hs)  w_done  <= 1'b1;
                    end
                end
                RESP: begin
`ifdef AXIL_ARB_TIMEOUT_EN
                    if (tmo) begin
                        if (g_bready) begin
                            drain      <= 1'b1;
                            last_grant <= g;
                            state      <= IDLE;
                        end
                    end else begin
                        if (!m_axil_bvalid) cnt <= cnt - 1'b1;
                        if (m_axil_bvalid && g_bready) begin
                            last_grant <= g;
                            state      <= IDLE;
                        end
                    end
`else
                    if (m_axil_bvalid && g_bready) begin
                        last_grant <= g;
                        state      <= IDLE;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_wr_arbiter.sv
// Directed self-checking bench for axil_wr_arbiter.
// Timeout steps are compiled in when AXIL_ARB_TIMEOUT_EN is defined.
module tb_axil_wr_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 40;
    localparam int SW  = 4;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rstn;

    logic [AW-1:0] s0_axil_awaddr, s1_axil_awaddr, m_axil_awaddr;
    logic          s0_axil_awvalid, s1_axil_awvalid, m_axil_awvalid;
    logic          s0_axil_awready, s1_axil_awready, m_axil_awready;
    logic [DW-1:0] s0_axil_wdata, s1_axil_wdata, m_axil_wdata;
    logic [SW-1:0] s0_axil_wstrb, s1_axil_wstrb, m_axil_wstrb;
    logic          s0_axil_wvalid, s1_axil_wvalid, m_axil_wvalid;
    logic          s0_axil_wready, s1_axil_wready, m_axil_wready;
    logic [1:0]    s0_axil_bresp, s1_axil_bresp, m_axil_bresp;
    logic          s0_axil_bvalid, s1_axil_bvalid, m_axil_bvalid;
    logic          s0_axil_bready, s1_axil_bready, m_axil_bready;

    int checks = 0;
    int errors = 0;
    int lat;

    always #5 clk = ~clk;

    axil_wr_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .STRB_WIDTH(SW),
        .TIMEOUT   (TMO)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .s0_axil_awaddr (s0_axil_awaddr),
        .s0_axil_awvalid(s0_axil_awvalid),
        .s0_axil_awready(s0_axil_awready),
        .s0_axil_wdata  (s0_axil_wdata),
        .s0_axil_wstrb  (s0_axil_wstrb),
        .s0_axil_wvalid (s0_axil_wvalid),
        .s0_axil_wready (s0_axil_wready),
        .s0_axil_bresp  (s0_axil_bresp),
        .s0_axil_bvalid (s0_axil_bvalid),
        .s0_axil_bready (s0_axil_bready),
        .s1_axil_awaddr (s1_axil_awaddr),
        .s1_axil_awvalid(s1_axil_awvalid),
        .s1_axil_awready(s1_axil_awready),
        .s1_axil_wdata  (s1_axil_wdata),
        .s1_axil_wstrb  (s1_axil_wstrb),
        .s1_axil_wvalid (s1_axil_wvalid),
        .s1_axil_wready (s1_axil_wready),
        .s1_axil_bresp  (s1_axil_bresp),
        .s1_axil_bvalid (s1_axil_bvalid),
        .s1_axil_bready (s1_axil_bready),
        .m_axil_awaddr  (m_axil_awaddr),
        .m_axil_awvalid (m_axil_awvalid),
        .m_axil_awready (m_axil_awready),
        .m_axil_wdata   (m_axil_wdata),
        .m_axil_wstrb   (m_axil_wstrb),
        .m_axil_wvalid  (m_axil_wvalid),
        .m_axil_wready  (m_axil_wready),
        .m_axil_bresp   (m_axil_bresp),
        .m_axil_bvalid  (m_axil_bvalid),
        .m_axil_bready  (m_axil_bready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic p_awready(input int p);
        return (p == 0) ? s0_axil_awready : s1_axil_awready;
    endfunction
    function automatic logic p_wready(input int p);
        return (p == 0) ? s0_axil_wready : s1_axil_wready;
    endfunction
    function automatic logic p_bvalid(input int p);
        return (p == 0) ? s0_axil_bvalid : s1_axil_bvalid;
    endfunction
    function automatic logic [1:0] p_bresp(input int p);
        return (p == 0) ? s0_axil_bresp : s1_axil_bresp;
    endfunction

    task automatic set_req(input int p, input logic v, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        if (p == 0) begin
            s0_axil_awvalid = v; s0_axil_wvalid = v;
            s0_axil_awaddr = a; s0_axil_wdata = d; s0_axil_wstrb = s;
        end else begin
            s1_axil_awvalid = v; s1_axil_wvalid = v;
            s1_axil_awaddr = a; s1_axil_wdata = d; s1_axil_wstrb = s;
        end
    endtask

    task automatic set_bready(input int p, input logic v);
        if (p == 0) s0_axil_bready = v;
        else        s1_axil_bready = v;
    endtask

    // Wait for the grant, then run AW/W with slave readies rising at the given XFER cycles.
    task automatic xfer(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input int aw_cyc, input int w_cyc,
                        output int wait_cyc);
        int k = 0;
        int n_aw = 0;
        int n_w = 0;
        int c = 0;
        do begin
            @(negedge clk); #1; k++;
        end while (!m_axil_awvalid && k < 60);
        wait_cyc = k;
        chk("grant_seen", 64'(m_axil_awvalid), 64'd1);
        chk("m_awaddr", 64'(m_axil_awaddr), 64'(a));
        chk("m_wdata", 64'(m_axil_wdata), 64'(d));
        chk("m_wstrb", 64'(m_axil_wstrb), 64'(s));
        while (!(n_aw > 0 && n_w > 0) && c < 20) begin
            c++;
            m_axil_awready = (c >= aw_cyc);
            m_axil_wready  = (c >= w_cyc);
            #1;
            chk("awvalid_mask", 64'(m_axil_awvalid), 64'(n_aw == 0));
            chk("wvalid_mask", 64'(m_axil_wvalid), 64'(n_w == 0));
            chk("awready_route", 64'(p_awready(p)), 64'(m_axil_awready && n_aw == 0));
            chk("wready_route", 64'(p_wready(p)), 64'(m_axil_wready && n_w == 0));
            chk("awready_other", 64'(p_awready(1 - p)), 64'd0);
            chk("wready_other", 64'(p_wready(1 - p)), 64'd0);
            if (m_axil_awvalid && m_axil_awready) n_aw++;
            if (m_axil_wvalid && m_axil_wready) n_w++;
            @(negedge clk); #1;
        end
        m_axil_awready = 1'b0;
        m_axil_wready  = 1'b0;
        set_req(p, 1'b0, '0, '0, '0);
        chk("aw_count", 64'(n_aw), 64'd1);
        chk("w_count", 64'(n_w), 64'd1);
        chk("xfer_cycles", 64'(c), 64'((aw_cyc > w_cyc) ? aw_cyc : w_cyc));
    endtask

    // RESP phase: b_lat idle cycles, then one B beat with the given response.
    task automatic bphase(input int p, input logic [1:0] resp, input int b_lat);
        set_bready(p, 1'b1);
        #1;
        for (int i = 0; i < b_lat; i++) begin
            chk("b_early", 64'(p_bvalid(p)), 64'd0);
            chk("m_bready_pass", 64'(m_axil_bready), 64'd1);
            @(negedge clk); #1;
        end
        m_axil_bvalid = 1'b1;
        m_axil_bresp  = resp;
        #1;
        chk("bvalid", 64'(p_bvalid(p)), 64'd1);
        chk("bresp", 64'(p_bresp(p)), 64'(resp));
        chk("bvalid_other", 64'(p_bvalid(1 - p)), 64'd0);
        chk("bresp_other", 64'(p_bresp(1 - p)), 64'd0);
        @(negedge clk); #1;
        // Slave still showing bvalid: a back-in-IDLE arbiter must not forward a second B.
        chk("single_b", 64'(p_bvalid(p)), 64'd0);
        chk("idle_m_bready", 64'(m_axil_bready), 64'd0);
        m_axil_bvalid = 1'b0;
        m_axil_bresp  = 2'b00;
        set_bready(p, 1'b0);
    endtask

    task automatic chk_all_low(input string tag);
        chk({tag, "_m_awvalid"}, 64'(m_axil_awvalid), 64'd0);
        chk({tag, "_m_wvalid"}, 64'(m_axil_wvalid), 64'd0);
        chk({tag, "_m_bready"}, 64'(m_axil_bready), 64'd0);
        chk({tag, "_s_ready"}, 64'({s0_axil_awready, s0_axil_wready,
                                    s1_axil_awready, s1_axil_wready}), 64'd0);
        chk({tag, "_s_b"}, 64'({s0_axil_bvalid, s1_axil_bvalid, s0_axil_bresp, s1_axil_bresp}),
            64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        s0_axil_bready = 1'b1; s1_axil_bready = 1'b1;
        m_axil_awready = 1'b1; m_axil_wready = 1'b1;
        m_axil_bvalid = 1'b1; m_axil_bresp = 2'b11;
        #2;
        // Reset: outputs low even with the slave side active.
        chk_all_low("reset");
        s0_axil_bready = 1'b0; s1_axil_bready = 1'b0;
        m_axil_awready = 1'b0; m_axil_wready = 1'b0;
        m_axil_bvalid = 1'b0; m_axil_bresp = 2'b00;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk); #1;
        chk_all_low("idle");

        // Round-robin from reset: port 0 first, then alternate.
        set_req(0, 1'b1, 40'h100, 32'h1111_0000, 4'h1);
        set_req(1, 1'b1, 40'h200, 32'h2222_0000, 4'h2);
        xfer(0, 40'h100, 32'h1111_0000, 4'h1, 1, 1, lat);
        bphase(0, 2'b00, 0);
        set_req(0, 1'b1, 40'h104, 32'h1111_0001, 4'h3);
        xfer(1, 40'h200, 32'h2222_0000, 4'h2, 1, 1, lat);
        bphase(1, 2'b00, 0);
        set_req(1, 1'b1, 40'h204, 32'h2222_0001, 4'h4);
        xfer(0, 40'h104, 32'h1111_0001, 4'h3, 1, 1, lat);
        bphase(0, 2'b00, 0);
        xfer(1, 40'h204, 32'h2222_0001, 4'h4, 1, 1, lat);
        bphase(1, 2'b00, 0);

        // Lone s0 write with an always-ready slave: visible one cycle after request.
        set_req(0, 1'b1, 40'h10, 32'hA5, 4'hF);
        xfer(0, 40'h10, 32'hA5, 4'hF, 1, 1, lat);
        chk("grant_latency", 64'(lat), 64'd1);
        bphase(0, 2'b00, 0);

        // Lone s0 again (last_grant is 0): AW ready at cycle 2, W ready at cycle 5.
        set_req(0, 1'b1, 40'h20, 32'hDEAD_BEEF, 4'hC);
        xfer(0, 40'h20, 32'hDEAD_BEEF, 4'hC, 2, 5, lat);
        bphase(0, 2'b00, 2);

        // Slave error for s1, then a clean s0 write.
        set_req(1, 1'b1, 40'h300, 32'h3333_3333, 4'hF);
        xfer(1, 40'h300, 32'h3333_3333, 4'hF, 3, 1, lat);
        bphase(1, 2'b10, 1);
        set_req(0, 1'b1, 40'h30, 32'h0404_0404, 4'h5);
        xfer(0, 40'h30, 32'h0404_0404, 4'h5, 1, 2, lat);
        bphase(0, 2'b00, 3);

        // Reset in the middle of XFER (last_grant is 0 beforehand).
        set_req(0, 1'b1, 40'h40, 32'h4444, 4'hF);
        @(negedge clk); #1;
        chk("pre_rst_awvalid", 64'(m_axil_awvalid), 64'd1);
        m_axil_awready = 1'b1; m_axil_wready = 1'b1;
        s0_axil_bready = 1'b1;
        rstn = 1'b0;
        #1;
        chk_all_low("mid_rst");
        set_req(0, 1'b0, '0, '0, '0);
        m_axil_awready = 1'b0; m_axil_wready = 1'b0;
        s0_axil_bready = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk_all_low("post_rst");
        set_req(0, 1'b1, 40'h50, 32'h5555, 4'h6);
        set_req(1, 1'b1, 40'h250, 32'h6666, 4'h9);
        xfer(0, 40'h50, 32'h5555, 4'h6, 1, 1, lat);
        bphase(0, 2'b00, 0);
        xfer(1, 40'h250, 32'h6666, 4'h9, 1, 1, lat);
        bphase(1, 2'b01, 0);

`ifdef AXIL_ARB_TIMEOUT_EN
        // No slave B: local SLVERR on the 16th RESP cycle, then drain the late B.
        set_req(0, 1'b1, 40'h60, 32'h7777, 4'hF);
        xfer(0, 40'h60, 32'h7777, 4'hF, 1, 1, lat);
        s0_axil_bready = 1'b1;
        #1;
        for (int i = 1; i < TMO; i++) begin
            chk("tmo_wait", 64'(s0_axil_bvalid), 64'd0);
            @(negedge clk); #1;
        end
        chk("tmo_bvalid", 64'(s0_axil_bvalid), 64'd1);
        chk("tmo_bresp", 64'(s0_axil_bresp), 64'd2);
        chk("tmo_m_bready", 64'(m_axil_bready), 64'd0);
        @(negedge clk); #1;
        s0_axil_bready = 1'b0;
        set_req(1, 1'b1, 40'h270, 32'h8888, 4'h3);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_m_bready", 64'(m_axil_bready), 64'd1);
            chk("drain_blocks", 64'(m_axil_awvalid), 64'd0);
            @(negedge clk);
        end
        m_axil_bvalid = 1'b1;
        @(negedge clk); #1;
        m_axil_bvalid = 1'b0;
        #1;
        chk("drain_done", 64'(m_axil_bready), 64'd0);
        xfer(1, 40'h270, 32'h8888, 4'h3, 1, 1, lat);
        chk("post_drain_latency", 64'(lat), 64'd1);
        bphase(1, 2'b00, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
